ps2_arrow_decoder: RTL and testbench

//   PS/2 keyboard receiver feeding the VGA square-mover. Syncs ps2_clk/ps2_data

---
 rtl/ps2_arrow_decoder_if.sv | 28 ++
 rtl/ps2_arrow_decoder.sv | 184 ++++++++++++++++++
 tb/tb_ps2_arrow_decoder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_arrow_decoder_if.sv
// Bundles the PS/2 pin pair with the decoded byte and arrow-key outputs.
//   ps2_clk/ps2_data  : raw PS/2 lines, asynchronous to vga_clk
//   scan_code         : last correctly received byte
//   scan_valid        : one-cycle pulse, scan_code updated
//   frame_err         : one-cycle pulse, framing/parity/stop error or timeout
//   u_arr..r_arr      : held-level arrow-key flags
// slave: the decoder side. master: the keyboard/consumer side.
interface ps2_arrow_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;
  logic       u_arr;
  logic       d_arr;
  logic       l_arr;
  logic       r_arr;

  modport slave (
    input  ps2_clk, ps2_data,
    output scan_code, scan_valid, frame_err, u_arr, d_arr, l_arr, r_arr
  );

  modport master (
    output ps2_clk, ps2_data,
    input  scan_code, scan_valid, frame_err, u_arr, d_arr, l_arr, r_arr
  );
endinterface

// File: rtl/ps2_arrow_decoder.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines into vga_clk, deframes
// 11-bit frames (start, 8 data LSB first, odd parity, stop), tracks E0/F0
// prefixes and drives held-level arrow-key flags plus raw scan codes.
//   vga_clk : system clock, all logic on posedge
//   reset_n : asynchronous active-low reset
//   bus     : PS/2 lines in, decoded byte / pulses / arrow flags out
module ps2_arrow_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TMR_W          = 16
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  ps2_arrow_decoder_if.slave   bus
);

  localparam int unsigned ARR_U = 3;
  localparam int unsigned ARR_D = 2;
  localparam int unsigned ARR_L = 1;
  localparam int unsigned ARR_R = 0;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]       r_clk_sync;
  logic [1:0]       r_data_sync;
  logic             r_clk_d;
  state_t           r_state;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic [TMR_W-1:0] r_timer;
  logic             r_ext;
  logic             r_brk;
  logic [7:0]       r_scan_code;
  logic             r_scan_valid;
  logic             r_frame_err;
  logic [3:0]       r_arrows;

  state_t           w_state_nxt;
  logic [2:0]       w_bit_cnt_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_parity_nxt;
  logic [TMR_W-1:0] w_timer_nxt;
  logic             w_ext_nxt;
  logic             w_brk_nxt;
  logic [7:0]       w_code_nxt;
  logic             w_valid_nxt;
  logic             w_err_nxt;
  logic [3:0]       w_arrows_nxt;

  logic w_fall;
  logic w_data;
  logic w_ok;
  logic w_timeout;

  assign w_fall    = r_clk_d & ~r_clk_sync[1];
  assign w_data    = r_data_sync[1];
  // Odd parity: data byte plus parity bit must contain an odd number of ones.
  assign w_ok      = w_data & (^{r_shift, r_parity});
  assign w_timeout = (r_state != S_IDLE) && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

  // State and output registers; sync FFs reset high because the bus idles high.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync   <= 2'b11;
      r_data_sync  <= 2'b11;
      r_clk_d      <= 1'b1;
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_timer      <= '0;
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_scan_code  <= '0;
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_arrows     <= '0;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], bus.ps2_clk};
      r_data_sync  <= {r_data_sync[0], bus.ps2_data};
      r_clk_d      <= r_clk_sync[1];
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_parity     <= w_parity_nxt;
      r_timer      <= w_timer_nxt;
      r_ext        <= w_ext_nxt;
      r_brk        <= w_brk_nxt;
      r_scan_code  <= w_code_nxt;
      r_scan_valid <= w_valid_nxt;
      r_frame_err  <= w_err_nxt;
      r_arrows     <= w_arrows_nxt;
    end
  end

  // Frame FSM, timeout and prefix/arrow tracking.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_timer_nxt   = r_timer + TMR_W'(1);
    w_ext_nxt     = r_ext;
    w_brk_nxt     = r_brk;
    w_code_nxt    = r_scan_code;
    w_valid_nxt   = 1'b0;
    w_err_nxt     = 1'b0;
    w_arrows_nxt  = r_arrows;

    if (r_state == S_IDLE) w_timer_nxt = '0;

    if (w_fall) begin
      w_timer_nxt = '0;
      unique case (r_state)
        S_IDLE: begin
          // A high data line on a fall is a glitch, not a start bit.
          if (!w_data) begin
            w_state_nxt   = S_DATA;
            w_bit_cnt_nxt = '0;
          end
        end
        S_DATA: begin
          w_shift_nxt   = {w_data, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        end
        S_PARITY: begin
          w_parity_nxt = w_data;
          w_state_nxt  = S_STOP;
        end
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (w_ok) begin
            w_valid_nxt = 1'b1;
            w_code_nxt  = r_shift;
            case (r_shift)
              8'hE0: w_ext_nxt = 1'b1;
              8'hF0: w_brk_nxt = 1'b1;
              // BAT pass or overrun: keyboard state is unknown, drop all keys.
              8'hAA, 8'h00, 8'hFF: begin
                w_arrows_nxt = '0;
                w_ext_nxt    = 1'b0;
                w_brk_nxt    = 1'b0;
              end
              default: begin
                // Only extended codes are arrows; plain ones are numpad keys.
                if (r_ext) begin
                  case (r_shift)
                    8'h75:   w_arrows_nxt[ARR_U] = ~r_brk;
                    8'h72:   w_arrows_nxt[ARR_D] = ~r_brk;
                    8'h6B:   w_arrows_nxt[ARR_L] = ~r_brk;
                    8'h74:   w_arrows_nxt[ARR_R] = ~r_brk;
                    default: ;
                  endcase
                end
                w_ext_nxt = 1'b0;
                w_brk_nxt = 1'b0;
              end
            endcase
          end else begin
            w_err_nxt = 1'b1;
            w_ext_nxt = 1'b0;
            w_brk_nxt = 1'b0;
          end
        end
      endcase
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_timer_nxt = '0;
      w_err_nxt   = 1'b1;
      w_ext_nxt   = 1'b0;
      w_brk_nxt   = 1'b0;
    end
  end

  assign bus.scan_code  = r_scan_code;
  assign bus.scan_valid = r_scan_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.u_arr      = r_arrows[ARR_U];
  assign bus.d_arr      = r_arrows[ARR_D];
  assign bus.l_arr      = r_arrows[ARR_L];
  assign bus.r_arr      = r_arrows[ARR_R];

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Bench for ps2_arrow_decoder: directed scenarios plus randomized byte
// streams, checked against a key-state model kept at the byte level.
module tb_ps2_arrow_decoder;
  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  always #20 vga_clk = ~vga_clk;

  ps2_arrow_decoder_if bus();

  ps2_arrow_decoder dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: {up, down, left, right}
  logic [7:0] m_code   = 8'h00;
  logic [3:0] m_arr    = 4'h0;
  bit         m_ext    = 1'b0;
  bit         m_brk    = 1'b0;
  int         m_nvalid = 0;
  int         m_nerr   = 0;
  int         n_valid  = 0;
  int         n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] dut_arr();
    return {bus.u_arr, bus.d_arr, bus.l_arr, bus.r_arr};
  endfunction

  // Byte-level keyboard model: what the host should believe after each byte.
  function automatic void model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      m_nerr++;
      return;
    end
    m_nvalid++;
    m_code = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hAA || b == 8'h00 || b == 8'hFF) begin
      m_arr = 4'h0;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      if (m_ext) begin
        if (b == 8'h75) m_arr[3] = !m_brk;
        if (b == 8'h72) m_arr[2] = !m_brk;
        if (b == 8'h6B) m_arr[1] = !m_brk;
        if (b == 8'h74) m_arr[0] = !m_brk;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_code = 8'h00;
    m_arr  = 4'h0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
  endfunction

  // Pulse counters, compared against the model at the end of the run.
  always @(negedge vga_clk) begin
    if (bus.scan_valid === 1'b1) n_valid++;
    if (bus.frame_err === 1'b1) n_err++;
  end

  task automatic half_bit();
    repeat ($urandom_range(4, 8)) @(negedge vga_clk);
  endtask

  task automatic ps2_bit(input bit v);
    bus.ps2_data = v;
    half_bit();
    bus.ps2_clk = 1'b0;
    half_bit();
    bus.ps2_clk = 1'b1;
  endtask

  // Full frame; checks pulse kind, scan_code and arrows on the pulse cycle
  // and that the pulse lasts exactly one cycle.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input string tag);
    logic p;
    bit   good;
    p    = (~^b) ^ bad_par;
    good = !(bad_par || bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    bus.ps2_data = !bad_stop;
    half_bit();
    bus.ps2_clk = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge vga_clk);
      if (bus.scan_valid || bus.frame_err) break;
    end
    model_byte(b, good);
    check({tag, " pulse"}, 32'({bus.scan_valid, bus.frame_err}), good ? 32'd2 : 32'd1);
    check({tag, " code"}, 32'(bus.scan_code), 32'(m_code));
    check({tag, " arrows"}, 32'(dut_arr()), 32'(m_arr));
    @(negedge vga_clk);
    check({tag, " pulse width"}, 32'({bus.scan_valid, bus.frame_err}), 32'd0);
    half_bit();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (10) @(negedge vga_clk);
  endtask

  logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hAA, 8'h00, 8'hFF, 8'h1C};

  initial begin
    int         waited;
    logic [7:0] b;
    bit         bp, bs;

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) @(negedge vga_clk);
    check("reset outputs", 32'({bus.scan_code, bus.scan_valid, bus.frame_err, dut_arr()}), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge vga_clk);
    check("post-reset outputs", 32'({bus.scan_code, bus.scan_valid, bus.frame_err, dut_arr()}), 32'd0);

    // Up arrow make then break.
    send_frame(8'hE0, 0, 0, "t1 E0");
    send_frame(8'h75, 0, 0, "t1 75");
    send_frame(8'h75, 0, 0, "t1 E0-less 75");
    send_frame(8'hE0, 0, 0, "t1 E0b");
    send_frame(8'hF0, 0, 0, "t1 F0");
    send_frame(8'h75, 0, 0, "t1 75 brk");

    // Bad parity after E0 clears the prefix.
    send_frame(8'hE0, 0, 0, "t2 E0");
    send_frame(8'h6B, 1, 0, "t2 6B badpar");
    send_frame(8'h6B, 0, 0, "t2 6B plain");

    // Idle-state glitch: fall with data high is ignored.
    bus.ps2_data = 1'b1;
    half_bit();
    bus.ps2_clk = 1'b0;
    half_bit();
    bus.ps2_clk = 1'b1;
    repeat (10) @(negedge vga_clk);

    // Stall mid-frame until the timeout fires.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i == 2 || i == 3);
    waited = 0;
    while (!bus.frame_err && waited < 50100) begin
      @(negedge vga_clk);
      waited++;
    end
    model_byte(8'h00, 0);
    check("t3 timeout err", 32'(bus.frame_err), 32'd1);
    check("t3 timeout late enough", 32'(waited >= 49990), 32'd1);
    check("t3 timeout code", 32'(bus.scan_code), 32'(m_code));
    @(negedge vga_clk);
    check("t3 timeout width", 32'(bus.frame_err), 32'd0);
    bus.ps2_data = 1'b1;
    repeat (10) @(negedge vga_clk);
    send_frame(8'h1C, 0, 0, "t3 1C");

    // BAT clears held arrows; plain 75 is not an arrow.
    send_frame(8'hE0, 0, 0, "t4 E0");
    send_frame(8'h74, 0, 0, "t4 74");
    send_frame(8'hAA, 0, 0, "t4 AA");
    send_frame(8'h75, 0, 0, "t4 75");

    // Reset mid-frame with down arrow held.
    send_frame(8'hE0, 0, 0, "t5 E0");
    send_frame(8'h72, 0, 0, "t5 72");
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0]);
    bus.ps2_data = 1'b1;
    half_bit();
    bus.ps2_clk = 1'b0;
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("t5 reset outputs", 32'({bus.scan_code, bus.scan_valid, bus.frame_err, dut_arr()}), 32'd0);
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (4) @(negedge vga_clk);
    reset_n = 1'b1;
    repeat (5) @(negedge vga_clk);
    send_frame(8'hE0, 0, 0, "t5 E0b");
    send_frame(8'h72, 0, 0, "t5 72b");

    // Bad stop bit keeps previous code.
    send_frame(8'hE0, 0, 0, "t6 E0");
    send_frame(8'h74, 0, 1, "t6 74 badstop");
    send_frame(8'h74, 0, 0, "t6 74 plain");

    // Randomized byte stream with occasional framing faults.
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 11);
      if (k >= 10) b = 8'($urandom);
      else b = pool[k];
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 11) == 0);
      send_frame(b, bp, bs, $sformatf("rnd%0d %02h", n, b));
    end

    repeat (10) @(negedge vga_clk);
    check("total scan_valid pulses", 32'(n_valid), 32'(m_nvalid));
    check("total frame_err pulses", 32'(n_err), 32'(m_nerr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
